// File: rtl/regblock_reader_if.sv
// regblock_reader_if
//  Request/response channel pair between a host (master) and the register-bank
//  read port (slave).
//
//  Handshake semantics (both channels): a transfer happens on a rising clock
//  edge where valid and ready are both 1. Once valid is raised the sender keeps
//  valid and its payload stable until that transfer happens. Ready may be
//  asserted independently of valid.
//
//  Signals
//   req_valid / req_ready / req_addr : read request channel (host -> block)
//   rsp_valid / rsp_ready            : response channel (block -> host)
//   rsp_data / rsp_err               : response payload
interface regblock_reader_if #(
  parameter int AW = 3
);
  logic          req_valid;
  logic          req_ready;
  logic [AW-1:0] req_addr;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [31:0]   rsp_data;
  logic          rsp_err;

  modport master (
    output req_valid, req_addr, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_err
  );

  modport slave (
    input  req_valid, req_addr, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_err
  );
endinterface

// File: rtl/regblock_reader.sv
// regblock_reader
//  Read-side port for a bank of 32-bit registers. A request samples the
//  addressed register's q value on the accepting edge and queues it in a
//  two-entry response FIFO, so host backpressure never loses a snapshot.
//
//  Ports
//   clk       clock, all logic on posedge
//   rst       synchronous reset, active-low
//   regs_q    register bank q values, reg i at [32*i+31:32*i]
//   bus       request/response channels (slave side)
//   rd_count  accepted reads, saturating at 16'hFFFF
module regblock_reader #(
  parameter int NREGS = 8,
  parameter int AW    = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREGS*32-1:0]  regs_q,
  regblock_reader_if.slave     bus,
  output logic [15:0]          rd_count
);

  // One extra bit so NREGS == 2**AW is representable for the range check.
  localparam logic [AW:0] NREGS_W = NREGS[AW:0];

  logic [1:0]  count;
  logic        wptr;
  logic        rptr;
  logic [31:0] mem_data [2];
  logic        mem_err  [2];

  logic        req_ready;
  logic        rsp_valid;
  logic        push;
  logic        pop;
  logic [AW:0] addr_ext;
  logic        sel_err;
  logic [31:0] sel_data;

  // req_ready comes only from the registered count, so there is no
  // combinational path from rsp_ready or req_valid into it.
  assign req_ready = (count != 2'd2);
  assign rsp_valid = (count != 2'd0);
  assign push      = bus.req_valid & req_ready;
  assign pop       = rsp_valid & bus.rsp_ready;

  assign bus.req_ready = req_ready;
  assign bus.rsp_valid = rsp_valid;
  assign bus.rsp_data  = mem_data[rptr];
  assign bus.rsp_err   = mem_err[rptr];

  assign addr_ext = {1'b0, bus.req_addr};
  assign sel_err  = (addr_ext >= NREGS_W);

  // Register select; out-of-range addresses fall through to zero data.
  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NREGS; i++) begin
      if (addr_ext == i[AW:0]) sel_data = regs_q[32*i +: 32];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      count       <= 2'd0;
      wptr        <= 1'b0;
      rptr        <= 1'b0;
      mem_data[0] <= '0;
      mem_data[1] <= '0;
      mem_err[0]  <= 1'b0;
      mem_err[1]  <= 1'b0;
      rd_count    <= '0;
    end else begin
      if (push) begin
        mem_data[wptr] <= sel_data;
        mem_err[wptr]  <= sel_err;
        wptr           <= ~wptr;
        if (rd_count != 16'hFFFF) rd_count <= rd_count + 16'd1;
      end
      if (pop) rptr <= ~rptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule
